// File: rtl/alu_arbiter_pkg.sv
// Shared ALU definitions: opcode type, opcode constants and legality check.
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_PASS = 4'b0000;
    localparam alu_op_t ALU_SLL  = 4'b0001;
    localparam alu_op_t ALU_ADD  = 4'b0010;
    localparam alu_op_t ALU_SUB  = 4'b0100;
    localparam alu_op_t ALU_SLT  = 4'b0101;
    localparam alu_op_t ALU_XOR  = 4'b0110;

    // True only for the opcodes the ALU implements. PASS is deliberately
    // excluded: it is the idle value, not something a requester may issue.
    function automatic logic alu_op_legal(input alu_op_t op);
        case (op)
            ALU_SLL, ALU_ADD, ALU_SUB, ALU_SLT, ALU_XOR: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Round-robin arbiter: a priority pointer, a combinational grant search
// starting at the pointer, and a pointer that moves just past each winner.
module rr_arbiter
    import alu_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_valid
);

    localparam int W = $clog2(N);

    logic [W-1:0] r_ptr;
    int           w_idx;

    // Scan requesters in order ptr, ptr+1, ... (mod N) and grant the first
    // valid one; nothing is granted while reset is held.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        w_idx     = 0;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                w_idx = (int'(r_ptr) + k) % N;
                for (int j = 0; j < N; j++) begin
                    if (!gnt_valid && (j == w_idx) && req[j]) begin
                        gnt[j]    = 1'b1;
                        gnt_idx   = W'(j);
                        gnt_valid = 1'b1;
                    end
                end
            end
        end
    end

    // After a grant the winner drops to lowest priority; the pointer wraps
    // explicitly because N need not be a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (gnt_valid) begin
            r_ptr <= (gnt_idx == W'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters: round-robin grant,
// operand steering onto the ALU, and a one-cycle registered tagged response.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_inp1,
    input  logic [NUM_REQ*32-1:0] req_inp2,
    input  logic [NUM_REQ*4-1:0]  req_ctrl,
    output logic [31:0]           alu_inp1,
    output logic [31:0]           alu_inp2,
    output logic [3:0]            alu_control,
    input  logic [31:0]           alu_result,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err
);

    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_gntIdx;
    logic               w_gntValid;
    logic [31:0]        w_aluInp1;
    logic [31:0]        w_aluInp2;
    alu_op_t            w_aluControl;

    logic               r_rspValid;
    logic [ID_W-1:0]    r_rspId;
    logic [31:0]        r_rspData;
    logic               r_rspErr;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rrArbiter (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .gnt       (w_gnt),
        .gnt_idx   (w_gntIdx),
        .gnt_valid (w_gntValid)
    );

    // Steer the winner's slices onto the ALU; with no winner the ALU sees a
    // constant all-zero PASS so its inputs do not toggle needlessly.
    always_comb begin
        w_aluInp1    = '0;
        w_aluInp2    = '0;
        w_aluControl = ALU_PASS;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_aluInp1    = req_inp1[32*i +: 32];
                w_aluInp2    = req_inp2[32*i +: 32];
                w_aluControl = req_ctrl[4*i +: 4];
            end
        end
    end

    // Capture the granted result one cycle later; id/data/err keep their last
    // value on idle cycles so only rsp_valid marks a new response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rspValid <= 1'b0;
            r_rspId    <= '0;
            r_rspData  <= '0;
            r_rspErr   <= 1'b0;
        end else begin
            r_rspValid <= w_gntValid;
            if (w_gntValid) begin
                r_rspId   <= w_gntIdx;
                r_rspData <= alu_result;
                r_rspErr  <= !alu_op_legal(w_aluControl);
            end
        end
    end

    assign req_ready   = w_gnt;
    assign alu_inp1    = w_aluInp1;
    assign alu_inp2    = w_aluInp2;
    assign alu_control = w_aluControl;
    assign rsp_valid   = r_rspValid;
    assign rsp_id      = r_rspId;
    assign rsp_data    = r_rspData;
    assign rsp_err     = r_rspErr;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a 2-requester instance covers handshake,
// steering, illegal opcodes, idle and reset; a 3-requester instance covers
// pointer wrap-around on a non power-of-two requester count.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic clk;
    logic rst;

    // 2-requester instance
    logic [1:0]  valid2;
    logic [1:0]  ready2;
    logic [63:0] inp1_2;
    logic [63:0] inp2_2;
    logic [7:0]  ctrl2;
    logic [31:0] aluA2, aluB2, aluRes2;
    logic [3:0]  aluC2;
    logic        rspValid2;
    logic [0:0]  rspId2;
    logic [31:0] rspData2;
    logic        rspErr2;

    // 3-requester instance
    logic [2:0]  valid3;
    logic [2:0]  ready3;
    logic [95:0] inp1_3;
    logic [95:0] inp2_3;
    logic [11:0] ctrl3;
    logic [31:0] aluA3, aluB3, aluRes3;
    logic [3:0]  aluC3;
    logic        rspValid3;
    logic [1:0]  rspId3;
    logic [31:0] rspData3;
    logic        rspErr3;

    int assertCount = 0;
    int failCount   = 0;

    // Reference ALU; unsupported opcodes pass operand A through.
    function automatic logic [31:0] aluModel(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            ALU_SLL: return a << b[4:0];
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_XOR: return a ^ b;
            default: return a;
        endcase
    endfunction

    assign aluRes2 = aluModel(aluA2, aluB2, aluC2);
    assign aluRes3 = aluModel(aluA3, aluB3, aluC3);

    alu_arbiter #(.NUM_REQ(2)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (valid2),
        .req_ready   (ready2),
        .req_inp1    (inp1_2),
        .req_inp2    (inp2_2),
        .req_ctrl    (ctrl2),
        .alu_inp1    (aluA2),
        .alu_inp2    (aluB2),
        .alu_control (aluC2),
        .alu_result  (aluRes2),
        .rsp_valid   (rspValid2),
        .rsp_id      (rspId2),
        .rsp_data    (rspData2),
        .rsp_err     (rspErr2)
    );

    alu_arbiter #(.NUM_REQ(3)) dut3 (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (valid3),
        .req_ready   (ready3),
        .req_inp1    (inp1_3),
        .req_inp2    (inp2_3),
        .req_ctrl    (ctrl3),
        .alu_inp1    (aluA3),
        .alu_inp2    (aluB3),
        .alu_control (aluC3),
        .alu_result  (aluRes3),
        .rsp_valid   (rspValid3),
        .rsp_id      (rspId3),
        .rsp_data    (rspData3),
        .rsp_err     (rspErr3)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive the 2-requester inputs on the falling edge, then settle 1 time unit.
    task automatic applyStimulus(input logic rstV, input logic [1:0] v,
                                 input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] c0,
                                 input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] c1);
        @(negedge clk);
        rst    = rstV;
        valid2 = v;
        inp1_2 = {a1, a0};
        inp2_2 = {b1, b0};
        ctrl2  = {c1, c0};
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst    = 1'b1;
        valid2 = '0; inp1_2 = '0; inp2_2 = '0; ctrl2 = '0;
        valid3 = '0; inp1_3 = '0; inp2_3 = '0; ctrl3 = '0;

        // Reset: valid requests must not be granted while rst is high
        applyStimulus(1'b1, 2'b11, 32'd5, 32'd3, ALU_ADD, 32'd10, 32'd4, ALU_SUB);
        checkOutput("rst_ready",   32'(ready2), 32'h0);
        checkOutput("rst_valid",   32'(rspValid2), 32'h0);
        checkOutput("rst_id",      32'(rspId2), 32'h0);
        checkOutput("rst_data",    rspData2, 32'h0);
        checkOutput("rst_err",     32'(rspErr2), 32'h0);
        checkOutput("rst_aluC",    32'(aluC2), 32'h0);
        checkOutput("rst_ptr",     32'(dut2.u_rrArbiter.r_ptr), 32'h0);

        // Both valid: grants alternate 0,1,0,1
        applyStimulus(1'b0, 2'b11, 32'd5, 32'd3, ALU_ADD, 32'd10, 32'd4, ALU_SUB);
        checkOutput("alt1_ready",  32'(ready2), 32'h1);
        checkOutput("alt1_aluA",   aluA2, 32'd5);
        checkOutput("alt1_aluB",   aluB2, 32'd3);
        checkOutput("alt1_aluC",   32'(aluC2), 32'(ALU_ADD));
        checkOutput("alt1_rspV",   32'(rspValid2), 32'h0);
        applyStimulus(1'b0, 2'b11, 32'd5, 32'd3, ALU_ADD, 32'd10, 32'd4, ALU_SUB);
        checkOutput("alt2_ready",  32'(ready2), 32'h2);
        checkOutput("alt2_aluC",   32'(aluC2), 32'(ALU_SUB));
        checkOutput("alt2_rspV",   32'(rspValid2), 32'h1);
        checkOutput("alt2_rspId",  32'(rspId2), 32'h0);
        checkOutput("alt2_rspD",   rspData2, 32'd8);
        checkOutput("alt2_rspE",   32'(rspErr2), 32'h0);
        applyStimulus(1'b0, 2'b11, 32'd5, 32'd3, ALU_ADD, 32'd10, 32'd4, ALU_SUB);
        checkOutput("alt3_ready",  32'(ready2), 32'h1);
        checkOutput("alt3_rspV",   32'(rspValid2), 32'h1);
        checkOutput("alt3_rspId",  32'(rspId2), 32'h1);
        checkOutput("alt3_rspD",   rspData2, 32'd6);
        applyStimulus(1'b0, 2'b11, 32'd5, 32'd3, ALU_ADD, 32'd10, 32'd4, ALU_SUB);
        checkOutput("alt4_ready",  32'(ready2), 32'h2);
        checkOutput("alt4_rspId",  32'(rspId2), 32'h0);
        checkOutput("alt4_rspD",   rspData2, 32'd8);

        // Only requester 1 valid with XOR: wins every cycle, pointer wraps to 0
        applyStimulus(1'b0, 2'b10, 32'd0, 32'd0, ALU_PASS, 32'hFF00FF00, 32'h0F0F0F0F, ALU_XOR);
        checkOutput("xor1_ready",  32'(ready2), 32'h2);
        checkOutput("xor1_ptr",    32'(dut2.u_rrArbiter.r_ptr), 32'h0);
        checkOutput("xor1_rspId",  32'(rspId2), 32'h1);
        checkOutput("xor1_rspD",   rspData2, 32'd6);
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b0, 2'b10, 32'd0, 32'd0, ALU_PASS, 32'hFF00FF00, 32'h0F0F0F0F, ALU_XOR);
            checkOutput("xorN_ready", 32'(ready2), 32'h2);
            checkOutput("xorN_ptr",   32'(dut2.u_rrArbiter.r_ptr), 32'h0);
            checkOutput("xorN_rspV",  32'(rspValid2), 32'h1);
            checkOutput("xorN_rspId", 32'(rspId2), 32'h1);
            checkOutput("xorN_rspD",  rspData2, 32'hF00FF00F);
        end

        // Requester 0: SLT 3,7 then illegal opcode 1111 passing 0x1234 through
        applyStimulus(1'b0, 2'b01, 32'd3, 32'd7, ALU_SLT, 32'd0, 32'd0, ALU_PASS);
        checkOutput("slt_ready",   32'(ready2), 32'h1);
        checkOutput("slt_prevD",   rspData2, 32'hF00FF00F);
        applyStimulus(1'b0, 2'b01, 32'h1234, 32'd5, 4'b1111, 32'd0, 32'd0, ALU_PASS);
        checkOutput("ill_ready",   32'(ready2), 32'h1);
        checkOutput("slt_rspV",    32'(rspValid2), 32'h1);
        checkOutput("slt_rspId",   32'(rspId2), 32'h0);
        checkOutput("slt_rspD",    rspData2, 32'd1);
        checkOutput("slt_rspE",    32'(rspErr2), 32'h0);

        // Idle: first cycle shows the illegal-op response, then nothing
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, ALU_PASS, 32'd0, 32'd0, ALU_PASS);
        checkOutput("ill_rspV",    32'(rspValid2), 32'h1);
        checkOutput("ill_rspD",    rspData2, 32'h1234);
        checkOutput("ill_rspE",    32'(rspErr2), 32'h1);
        checkOutput("idle0_ready", 32'(ready2), 32'h0);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, ALU_PASS, 32'd0, 32'd0, ALU_PASS);
            checkOutput("idle_rspV",  32'(rspValid2), 32'h0);
            checkOutput("idle_aluC",  32'(aluC2), 32'h0);
            checkOutput("idle_aluA",  aluA2, 32'h0);
            checkOutput("idle_aluB",  aluB2, 32'h0);
            checkOutput("idle_ptr",   32'(dut2.u_rrArbiter.r_ptr), 32'h1);
            checkOutput("idle_holdD", rspData2, 32'h1234);
            checkOutput("idle_holdE", 32'(rspErr2), 32'h1);
        end

        // Grant to 0 (ptr=1, so search wraps), then reset before the capturing edge
        applyStimulus(1'b0, 2'b01, 32'd7, 32'd7, ALU_ADD, 32'd9, 32'd2, ALU_SUB);
        checkOutput("pre_rst_ready", 32'(ready2), 32'h1);
        #2 rst = 1'b1;
        #1;
        checkOutput("in_rst_ready",  32'(ready2), 32'h0);
        checkOutput("in_rst_aluA",   aluA2, 32'h0);
        applyStimulus(1'b1, 2'b11, 32'd7, 32'd7, ALU_ADD, 32'd9, 32'd2, ALU_SUB);
        checkOutput("lost_rspV",     32'(rspValid2), 32'h0);
        checkOutput("lost_ptr",      32'(dut2.u_rrArbiter.r_ptr), 32'h0);
        checkOutput("lost_ready",    32'(ready2), 32'h0);
        checkOutput("lost_rspD",     rspData2, 32'h0);
        applyStimulus(1'b0, 2'b11, 32'd7, 32'd7, ALU_ADD, 32'd9, 32'd2, ALU_SUB);
        checkOutput("post_rst_ready", 32'(ready2), 32'h1);
        checkOutput("post_rst_rspV",  32'(rspValid2), 32'h0);
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, ALU_PASS, 32'd0, 32'd0, ALU_PASS);
        checkOutput("retry_rspV",    32'(rspValid2), 32'h1);
        checkOutput("retry_rspId",   32'(rspId2), 32'h0);
        checkOutput("retry_rspD",    rspData2, 32'd14);

        // NUM_REQ=3, all valid: grants 0,1,2,0 with wrap after ptr=2
        @(negedge clk);
        valid3 = 3'b111;
        inp1_3 = {32'd3, 32'd2, 32'd1};
        inp2_3 = {32'd3, 32'd2, 32'd1};
        ctrl3  = {ALU_ADD, ALU_ADD, ALU_ADD};
        #1;
        checkOutput("r3_g0_ready", 32'(ready3), 32'h1);
        checkOutput("r3_g0_ptr",   32'(dut3.u_rrArbiter.r_ptr), 32'h0);
        @(negedge clk); #1;
        checkOutput("r3_g1_ready", 32'(ready3), 32'h2);
        checkOutput("r3_g1_rspId", 32'(rspId3), 32'h0);
        checkOutput("r3_g1_rspD",  rspData3, 32'd2);
        @(negedge clk); #1;
        checkOutput("r3_g2_ptr",   32'(dut3.u_rrArbiter.r_ptr), 32'h2);
        checkOutput("r3_g2_ready", 32'(ready3), 32'h4);
        checkOutput("r3_g2_rspId", 32'(rspId3), 32'h1);
        checkOutput("r3_g2_rspD",  rspData3, 32'd4);
        @(negedge clk); #1;
        checkOutput("r3_wrap_ptr",   32'(dut3.u_rrArbiter.r_ptr), 32'h0);
        checkOutput("r3_wrap_ready", 32'(ready3), 32'h1);
        checkOutput("r3_wrap_rspId", 32'(rspId3), 32'h2);
        checkOutput("r3_wrap_rspD",  rspData3, 32'd6);
        @(negedge clk);
        valid3 = 3'b000;
        #1;
        checkOutput("r3_last_rspV",  32'(rspValid3), 32'h1);
        checkOutput("r3_last_rspId", 32'(rspId3), 32'h0);
        checkOutput("r3_idle_ready", 32'(ready3), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single combinational ALU between NUM_REQ requesters, for example the execute stage, the branch-target adder path and the address-generation path.
- One operation is granted per cycle under round-robin priority.
- The winner's operands and opcode are steered onto the ALU inputs.
- The ALU result is registered and returned, tagged with the winner's id, one cycle later.
- Opcodes outside the supported set are flagged on the response.

Parameters:
- NUM_REQ, 2: number of requesters; legal range 2..8.
- ID_W, $clog2(NUM_REQ): width of rsp_id.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant, one-hot or zero, combinational.
- req_inp1  in  NUM_REQ*32  packed operand A; slice i = bits [32*i+31:32*i].
- req_inp2  in  NUM_REQ*32  packed operand B.
- req_ctrl  in  NUM_REQ*4  packed ALU opcode.
- alu_inp1  out  32  operand A driven to the ALU.
- alu_inp2  out  32  operand B driven to the ALU.
- alu_control  out  4  opcode driven to the ALU.
- alu_result  in  32  combinational result returned by the ALU.
- rsp_valid  out  1  response valid; asserted for exactly one cycle per accepted request.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_data  out  32  registered ALU result.
- rsp_err  out  1  accepted opcode was not in {0001, 0010, 0100, 0101, 0110}.

Behaviour:
- Handshake:
  - A request transfers in any cycle where req_valid[i] and req_ready[i] are both high.
  - While req_valid[i] is high and req_ready[i] is low, requester i holds its operands and opcode stable.
  - req_valid[i] does not depend on req_ready[i].
- Arbitration (combinational):
  - State is the priority pointer ptr (ID_W bits).
  - Search order is ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - The first requester with req_valid high is granted; req_ready is one-hot on that index.
  - If no requester is valid, req_ready is all zeros.
- Pointer update:
  - On a grant to index g, ptr <= (g+1) mod NUM_REQ. The wrap from NUM_REQ-1 goes to 0.
  - With no grant, ptr holds.
- ALU steering (combinational):
  - With a grant, alu_inp1, alu_inp2 and alu_control carry the granted slices.
  - With no grant, all three are driven to 0 (opcode 0000, pass-through), so the ALU sees constant inputs.
- Response (registered, latency 1):
  - The edge after a grant to g loads rsp_valid=1, rsp_id=g, rsp_data=alu_result, rsp_err=(opcode not legal).
  - A cycle with no grant loads rsp_valid=0. rsp_id, rsp_data and rsp_err hold their previous values.
- Response backpressure: there is none. Requesters sample the response in the cycle rsp_valid is high.
- Throughput: one operation per cycle. Back-to-back grants give a response every cycle.
- Illegal opcode: the operation still executes and its result is returned (the ALU passes inp1 through), with rsp_err=1. The arbiter does not stall.
- Reset:
  - While rst is high: ptr=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0.
  - While rst is high, req_ready is forced to all zeros and the ALU outputs to 0; no request is accepted.
  - A reset asserted in the cycle after a grant suppresses that response. rsp_valid stays 0 and the operation is lost; the requester retries after reset.
- Fairness: with all requesters continuously valid, grants rotate 0, 1, ..., NUM_REQ-1, 0. Each requester waits at most NUM_REQ-1 cycles.

Decomposition:
- Shared package alu_pkg, holding:
  - opcode constants ALU_SLL=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0100, ALU_SLT=4'b0101, ALU_XOR=4'b0110, ALU_PASS=4'b0000;
  - typedef alu_op_t (logic [3:0]);
  - function alu_op_legal(alu_op_t) returning 1 for the five legal opcodes.
- Sub-module rr_arbiter (parameter N), containing ptr, the grant search and the pointer update.
- Ports of rr_arbiter: clk, rst, req[N], gnt[N] (one-hot), gnt_idx, gnt_valid.
- alu_arbiter adds the operand mux, the ALU steering and the response register.

Test Plan:
- Reset, then req_valid=2'b11 held with requester 0 ADD 5,3 and requester 1 SUB 10,4. Required: grants alternate 0,1,0,1. Responses are rsp_id=0 with rsp_data=8, then rsp_id=1 with rsp_data=6, each one cycle after its grant.
- Only requester 1 valid, XOR 0xFF00FF00, 0x0F0F0F0F, for 3 cycles. Required: req_ready=2'b10 every cycle and rsp_data=0xF00FF00F each cycle. ptr wraps to 0 after each grant.
- NUM_REQ=3, all valid, with ptr=2 after a grant to 1. Required: the next grant goes to 2 and the following one to 0, confirming wrap-around.
- Requester 0 issues SLT 3,7, then opcode 4'b1111 with inp1=0x1234. Required: first response rsp_data=1, rsp_err=0. Second response rsp_data=0x1234, rsp_err=1.
- No requests for 4 cycles. Required: rsp_valid=0, alu_control=0000, alu_inp1=alu_inp2=0, and ptr unchanged.
- Grant issued, then rst=1 in the following cycle. Required: rsp_valid stays 0, ptr=0 and req_ready=0 during reset. After rst drops, requester 0 wins first.
